// File: rtl/mul24_rr_scheduler.sv
// rtl/mul24_rr_scheduler.sv - round-robin scheduler sharing one 24x24 unsigned multiplier
// Optional perf counters (o_perf_busy/o_perf_stall) are built when MUL24_SCHED_PERF_EN is defined.
module mul24_unsigned (
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [47:0] p
);
  assign p = {24'b0, a} * {24'b0, b};
endmodule

module mul24_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int PIPE_STAGES = 2,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  output logic [NUM_REQ-1:0]      o_req_ready,
  input  logic [NUM_REQ*24-1:0]   i_req_a,
  input  logic [NUM_REQ*24-1:0]   i_req_b,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output logic [ID_W-1:0]         o_res_id,
  output logic [47:0]             o_res_product
`ifdef MUL24_SCHED_PERF_EN
  ,
  output logic [31:0]             o_perf_busy,
  output logic [31:0]             o_perf_stall
`endif
);

  logic            stall;
  logic            s1_en;
  logic            s1_valid;
  logic [23:0]     s1_a, s1_b;
  logic [ID_W-1:0] s1_id;
  logic [47:0]     mul_p;
  logic [ID_W-1:0] ptr, grant_id, idx;
  logic            grant_any;
  logic            accept;
  logic [23:0]     sel_a, sel_b;

  assign stall = o_res_valid & ~i_res_ready;

  // Scan downward so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (i_req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end

  assign accept = grant_any & ~stall & s1_en & i_rst_n;

  always_comb begin
    o_req_ready = '0;
    if (accept) o_req_ready[grant_id] = 1'b1;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_W'(k)) begin
        sel_a = i_req_a[k*24 +: 24];
        sel_b = i_req_b[k*24 +: 24];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      ptr      <= '0;
    end else begin
      if (s1_en) s1_valid <= accept;
      if (accept) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= grant_id;
        ptr   <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
    end
  end

  mul24_unsigned u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (mul_p)
  );

  generate
    if (PIPE_STAGES == 1) begin : g_p1
      assign s1_en         = ~s1_valid | i_res_ready;
      assign o_res_valid   = s1_valid;
      assign o_res_id      = s1_id;
      assign o_res_product = mul_p;
    end else begin : g_pn
      localparam int N = PIPE_STAGES - 1;
      logic [N-1:0]    pv;
      logic [47:0]     pp  [N];
      logic [ID_W-1:0] pid [N];
      logic [N:0]      en;

      // A stage may load when it is empty or its successor moves, so bubbles collapse under stall.
      always_comb begin
        en    = '0;
        en[N] = i_res_ready;
        for (int j = N - 1; j >= 0; j--) en[j] = ~pv[j] | en[j+1];
      end

      assign s1_en = ~s1_valid | en[0];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          pv <= '0;
          for (int j = 0; j < N; j++) begin
            pp[j]  <= '0;
            pid[j] <= '0;
          end
        end else begin
          if (en[0]) begin
            pv[0]  <= s1_valid;
            pp[0]  <= mul_p;
            pid[0] <= s1_id;
          end
          for (int j = 1; j < N; j++) begin
            if (en[j]) begin
              pv[j]  <= pv[j-1];
              pp[j]  <= pp[j-1];
              pid[j] <= pid[j-1];
            end
          end
        end
      end

      assign o_res_valid   = pv[N-1];
      assign o_res_id      = pid[N-1];
      assign o_res_product = pp[N-1];
    end
  endgenerate

`ifdef MUL24_SCHED_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_perf_busy  <= '0;
      o_perf_stall <= '0;
    end else begin
      if (o_res_valid && o_perf_busy != 32'hFFFF_FFFF) o_perf_busy <= o_perf_busy + 32'd1;
      if (stall && o_perf_stall != 32'hFFFF_FFFF) o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule
